alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single combinational ALU among NUM_REQ requesters (e.g. PC incrementer, load/store address gen, execute stage).
//  Round-robin arbitration, one op accepted per cycle, fully pipelined: request -> operand register -> ALU -> response register.
//  Drives the ALU operand/control inputs and returns each result to the requester that issued it.
// PARAMETERS
//  NUM_REQ  3   number of requesters (>=2)
//  DATA_W   32  operand/result width
//  CTRL_W   6   ALU control width (aluControl encoding, passed through unmodified)
// PORTS
//  clk        in   1               clock, rising edge
//  rst        in   1               reset, asynchronous, active-high
//  stall      in   1               high: no new request accepted this cycle
//  req_valid  in   NUM_REQ         per-requester request
//  req_in1    in   NUM_REQ*DATA_W  operand 1, requester i at [i*DATA_W +: DATA_W]
//  req_in2    in   NUM_REQ*DATA_W  operand 2, same packing
//  req_ctrl   in   NUM_REQ*CTRL_W  ALU control, requester i at [i*CTRL_W +: CTRL_W]
//  req_ready  out  NUM_REQ         one-hot grant/accept, combinational
//  alu_in1    out  DATA_W          to ALU in1 (registered)
//  alu_in2    out  DATA_W          to ALU in2 (registered)
//  alu_ctrl   out  CTRL_W          to ALU aluControl (registered)
//  alu_out    in   DATA_W          from ALU out
//  rsp_valid  out  NUM_REQ         one-hot result strobe, 1 cycle
//  rsp_data   out  DATA_W          result, valid when any rsp_valid bit set
//  busy       out  1               op register holds an in-flight op
// BEHAVIOUR
//  Reset: ptr=0, op_valid=0, op_id=0, alu_in1/alu_in2/alu_ctrl=0, rsp_valid=0, rsp_data=0, busy=0; req_ready=0 while rst high.
//  Arbitration (comb): if !stall and |req_valid, grant first i with req_valid[i] searching ptr, ptr+1, ... wrapping mod NUM_REQ.
//   req_ready has exactly the granted bit set, else all zero; never depends on req_ready itself.
//  Handshake: transfer when req_valid[i] && req_ready[i]. Requester holds valid and operands stable until accepted.
//  On accept at cycle T (edge ending T): alu_in1/in2/ctrl <= granted operands, op_id <= i, op_valid <= 1, ptr <= (i+1) mod NUM_REQ.
//  No accept: op_valid <= 0, ptr unchanged; alu_* hold last values (no toggling when idle).
//  Cycle T+1: ALU evaluates registered operands; at edge: rsp_data <= alu_out, rsp_valid <= op_valid ? onehot(op_id) : 0.
//  Latency: accept cycle T -> rsp_valid[i] high in cycle T+2 for exactly 1 cycle. Throughput 1 op/cycle, back-to-back allowed.
//  rsp_data holds last result when rsp_valid=0. No response backpressure; requester must sink rsp in that cycle.
//  busy = op_valid.
//  ptr width = max(1, clog2(NUM_REQ)); ptr wraps NUM_REQ-1 -> 0. Single persistent requester is granted every cycle.
//  stall: blocks acceptance only; ops already in op register still complete and respond. ptr frozen while stalled.
//  stall and req_valid rising same cycle: not accepted; accepted first cycle stall is low.
//  Reset mid-operation: in-flight ops dropped, no rsp_valid generated; after reset release arbitration restarts at ptr=0.
//  Arithmetic: none performed here; widths passed through; alu_out captured unmodified.
// TESTING
//  1 Reset: assert rst mid-run -> all outputs 0 immediately (async), req_ready=0 until rst low.
//  2 Single op: req0 in1=5 in2=3 ctrl=6'b100000 (add), ALU model -> req_ready=001 at T, rsp_valid=001 rsp_data=8 at T+2.
//  3 Round-robin: req_valid=111 held 6 cycles from ptr=0 -> req_ready 001,010,100,001,010,100; rsp_valid same seq 2 cycles later.
//  4 Skip/wrap: ptr=2, req_valid=011 -> grant 001 then 010; ctrl=6'b100010 in1=10 in2=4 -> rsp_data=6 for req1.
//  5 Stall: req1 valid, stall=1 for 3 cycles -> req_ready=0, ptr frozen; op accepted the cycle before stall still responds at +2.
//  6 Reset in flight: accept req2 at T, rst pulse in T+1 -> no rsp_valid at T+2; next request granted from ptr=0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin front end for one shared combinational ALU: grant -> operand
// register -> external ALU -> response register, routed back to the issuer.
module alu_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int CTRL_W  = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_in1,
  input  logic [NUM_REQ*DATA_W-1:0] req_in2,
  input  logic [NUM_REQ*CTRL_W-1:0] req_ctrl,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         alu_in1,
  output logic [DATA_W-1:0]         alu_in2,
  output logic [CTRL_W-1:0]         alu_ctrl,
  input  logic [DATA_W-1:0]         alu_out,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic               op_valid_q;
  logic [ID_W-1:0]    op_id_q;
  logic [DATA_W-1:0]  alu_in1_q, alu_in2_q, rsp_data_q;
  logic [CTRL_W-1:0]  alu_ctrl_q;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;

  logic [NUM_REQ-1:0] grant_oh;
  logic [ID_W-1:0]    grant_id;
  logic               found;
  logic               accept;
  int                 idx;

  // Search ptr, ptr+1, ... wrapping; the first valid requester wins.
  always_comb begin
    grant_oh = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    if (!rst && !stall) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (int'(ptr_q) + k) % NUM_REQ;
        if (!found && req_valid[idx]) begin
          found         = 1'b1;
          grant_oh[idx] = 1'b1;
          grant_id      = ID_W'(idx);
        end
      end
    end
  end

  assign accept = found;
  assign ptr_d  = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
      assign rsp_valid_d[gi] = op_valid_q && (op_id_q == ID_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      op_valid_q  <= 1'b0;
      op_id_q     <= '0;
      alu_in1_q   <= '0;
      alu_in2_q   <= '0;
      alu_ctrl_q  <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      op_valid_q  <= accept;
      rsp_valid_q <= rsp_valid_d;
      if (accept) begin
        alu_in1_q  <= req_in1[int'(grant_id)*DATA_W +: DATA_W];
        alu_in2_q  <= req_in2[int'(grant_id)*DATA_W +: DATA_W];
        alu_ctrl_q <= req_ctrl[int'(grant_id)*CTRL_W +: CTRL_W];
        op_id_q    <= grant_id;
        ptr_q      <= ptr_d;
      end
      // Result register only moves when a real op completes, so it holds when idle.
      if (op_valid_q) begin
        rsp_data_q <= alu_out;
      end
    end
  end

  assign req_ready = grant_oh;
  assign alu_in1   = alu_in1_q;
  assign alu_in2   = alu_in2_q;
  assign alu_ctrl  = alu_ctrl_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = op_valid_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU and a response
// scoreboard drained by an independent monitor.
module tb_alu_arbiter;
  localparam int NR = 3;
  localparam int DW = 32;
  localparam int CW = 6;
  localparam logic [CW-1:0] ADD = 6'b100000;
  localparam logic [CW-1:0] SUB = 6'b100010;
  localparam logic [CW-1:0] OR_ = 6'b100101;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             stall = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*DW-1:0] req_in1, req_in2;
  logic [NR*CW-1:0] req_ctrl;
  logic [NR-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]    alu_in1, alu_in2, alu_out, rsp_data;
  logic [CW-1:0]    alu_ctrl;
  logic             busy;

  logic [DW-1:0] in1 [NR];
  logic [DW-1:0] in2 [NR];
  logic [CW-1:0] ctl [NR];

  typedef struct {
    logic [NR-1:0] oh;
    logic [DW-1:0] data;
  } rsp_t;
  rsp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  logic prev_acc = 1'b0;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NR; gi++) begin : g_pack
      assign req_in1[gi*DW +: DW]  = in1[gi];
      assign req_in2[gi*DW +: DW]  = in2[gi];
      assign req_ctrl[gi*CW +: CW] = ctl[gi];
    end
  endgenerate

  always_comb begin
    case (alu_ctrl)
      ADD:     alu_out = alu_in1 + alu_in2;
      SUB:     alu_out = alu_in1 - alu_in2;
      OR_:     alu_out = alu_in1 | alu_in2;
      default: alu_out = alu_in1 & alu_in2;
    endcase
  end

  alu_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .CTRL_W(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .req_valid(req_valid),
    .req_in1(req_in1), .req_in2(req_in2), .req_ctrl(req_ctrl),
    .req_ready(req_ready), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_ctrl(alu_ctrl), .alu_out(alu_out), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .busy(busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h at %0t", name, act, $time);
    end
  endtask

  // One request cycle, entered at posedge+1; expectation supplied by hand.
  task automatic cycle(input logic [NR-1:0] v, input logic s,
                       input logic [NR-1:0] exp_rdy, input logic [DW-1:0] exp_data);
    rsp_t e;
    req_valid = v;
    stall     = s;
    @(negedge clk);
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    check("busy", 64'(busy), 64'(prev_acc));
    if (exp_rdy != '0) begin
      e.oh = exp_rdy;
      e.data = exp_data;
      sb.push_back(e);
    end
    prev_acc = (exp_rdy != '0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every response strobe must match the oldest expected response.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid !== '0) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 64'(rsp_valid), 64'(0));
        end else begin
          e = sb.pop_front();
          check("rsp_valid", 64'(rsp_valid), 64'(e.oh));
          check("rsp_data", 64'(rsp_data), 64'(e.data));
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < NR; k++) begin
      in1[k] = '0; in2[k] = '0; ctl[k] = ADD;
    end
    req_valid = 3'b111;
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_alu_in1", 64'(alu_in1), 64'(0));
    check("rst_rsp", 64'(rsp_valid), 64'(0));
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Single op: 5 + 3.
    in1[0] = 5; in2[0] = 3; ctl[0] = ADD;
    cycle(3'b001, 1'b0, 3'b001, 32'd8);
    cycle(3'b000, 1'b0, 3'b000, 32'd0);
    cycle(3'b000, 1'b0, 3'b000, 32'd0);
    check("alu_in1_hold", 64'(alu_in1), 64'd5);

    // Asynchronous reset mid-run.
    #2;
    rst = 1'b1;
    req_valid = 3'b111;
    #1;
    check("async_alu_in1", 64'(alu_in1), 64'(0));
    check("async_rsp_data", 64'(rsp_data), 64'(0));
    check("async_ready", 64'(req_ready), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    prev_acc = 1'b0;

    // Round-robin with all three requesters persistent.
    in1[0] = 1;     in2[0] = 1;     ctl[0] = ADD;
    in1[1] = 20;    in2[1] = 7;     ctl[1] = SUB;
    in1[2] = 'hF0;  in2[2] = 'h0F;  ctl[2] = OR_;
    for (int r = 0; r < 2; r++) begin
      cycle(3'b111, 1'b0, 3'b001, 32'd2);
      cycle(3'b111, 1'b0, 3'b010, 32'd13);
      cycle(3'b111, 1'b0, 3'b100, 32'hFF);
    end

    // Skip and wrap: move ptr to 2, then 011 grants 001 then 010.
    in1[1] = 10; in2[1] = 4; ctl[1] = SUB;
    cycle(3'b010, 1'b0, 3'b010, 32'd6);
    cycle(3'b011, 1'b0, 3'b001, 32'd2);
    cycle(3'b011, 1'b0, 3'b010, 32'd6);

    // Stall: accepted op before stall still responds; ptr stays at 2.
    cycle(3'b010, 1'b0, 3'b010, 32'd6);
    cycle(3'b010, 1'b1, 3'b000, 32'd0);
    cycle(3'b010, 1'b1, 3'b000, 32'd0);
    cycle(3'b010, 1'b1, 3'b000, 32'd0);
    cycle(3'b111, 1'b0, 3'b100, 32'hFF);
    cycle(3'b000, 1'b0, 3'b000, 32'd0);
    cycle(3'b000, 1'b0, 3'b000, 32'd0);

    // Reset while an op is in flight: no response, ptr back to 0.
    cycle(3'b010, 1'b0, 3'b010, 32'd6);
    req_valid = '0;
    check("busy_inflight", 64'(busy), 64'd1);
    #1;
    rst = 1'b1;
    sb.delete();
    #2;
    rst = 1'b0;
    prev_acc = 1'b0;
    @(negedge clk);
    check("inflight_dropped_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("inflight_no_rsp", 64'(rsp_valid), 64'(0));
    @(posedge clk); #1;
    cycle(3'b111, 1'b0, 3'b001, 32'd2);
    cycle(3'b000, 1'b0, 3'b000, 32'd0);

    for (int w = 0; w < 10 && sb.size() != 0; w++) @(posedge clk);
    #1;
    if (sb.size() != 0) check("rsp_timeout", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
